// File: rtl/dbus_uncached_bridge.sv
// Uncached/MMIO bridge: turns each CPU data-bus request into one single-beat cbus transaction.
// Holds at most one request in flight and returns the full aligned 64-bit word.

package common;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [2:0]  msize_t;
  typedef logic [7:0]  mlen_t;
  typedef logic [1:0]  axi_burst_type_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  localparam mlen_t MLEN1 = 8'd0;

  localparam axi_burst_type_t AXI_BURST_FIXED = 2'd0;
  localparam axi_burst_type_t AXI_BURST_INCR  = 2'd1;
  localparam axi_burst_type_t AXI_BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;
endpackage

module dbus_uncached_bridge
  import common::*;
(
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e  r_state;
  state_e  w_state_next;
  addr_t   r_addr;
  msize_t  r_size;
  strobe_t r_strobe;
  word_t   r_wdata;
  word_t   r_rdata;
  logic    r_is_write;
  logic    w_latch;
  logic    w_capture;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_size     <= '0;
      r_strobe   <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr     <= dreq.addr;
        r_size     <= dreq.size;
        r_strobe   <= dreq.strobe;
        r_wdata    <= dreq.data;
        r_is_write <= (dreq.strobe != '0);
      end
      if (w_capture) begin
        r_rdata <= r_is_write ? '0 : cresp.data;
      end
    end
  end

  // creq and dresp come only from state and registers; no input reaches an output directly.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    creq         = '0;
    dresp        = '0;
    unique case (r_state)
      StIdle: begin
        if (dreq.valid) begin
          w_latch      = 1'b1;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        creq.valid    = 1'b1;
        creq.is_write = r_is_write;
        creq.size     = r_size;
        creq.addr     = r_addr;
        creq.strobe   = r_strobe;
        creq.data     = r_wdata;
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_INCR;
        // ready without last is illegal for a single beat; keep waiting for the real last.
        if (cresp.ready && cresp.last) begin
          w_capture    = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = r_rdata;
        w_state_next  = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

`ifdef BRIDGE_PROTOCOL_CHECKS
  always_ff @(posedge clk) begin
    if (reset && (r_state == StBusy) && cresp.ready && !cresp.last) begin
      $error("dbus_uncached_bridge: cresp.ready without cresp.last on single-beat transfer");
    end
  end
`endif

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Directed bench for dbus_uncached_bridge: vector table of single transactions plus
// hand-written sequences for protocol error, mid-flight drop, reset and back-to-back.

module tb_dbus_uncached_bridge;
  import common::*;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  dbus_uncached_bridge u_dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completed cbus transactions, used to spot duplicates.
  always @(posedge clk) begin
    if (reset && creq.valid && cresp.ready && cresp.last) n_txn <= n_txn + 1;
  end

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    int          wait_n;
    logic [63:0] rdata;
    logic        exp_write;
    logic [63:0] exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int cyc;
    dreq        = '0;
    dreq.valid  = 1'b1;
    dreq.addr   = v.addr;
    dreq.size   = v.size;
    dreq.strobe = v.strobe;
    dreq.data   = v.wdata;
    cresp       = '0;
    step();
    cyc = 1;
    chk({tag, ".creq.valid"}, 64'(creq.valid), 64'(1));
    chk({tag, ".creq.is_write"}, 64'(creq.is_write), 64'(v.exp_write));
    chk({tag, ".creq.addr"}, creq.addr, v.addr);
    chk({tag, ".creq.size"}, 64'(creq.size), 64'(v.size));
    chk({tag, ".creq.strobe"}, 64'(creq.strobe), 64'(v.strobe));
    chk({tag, ".creq.data"}, creq.data, v.wdata);
    chk({tag, ".creq.len"}, 64'(creq.len), 64'(8'd0));
    chk({tag, ".creq.burst"}, 64'(creq.burst), 64'(2'd1));
    chk({tag, ".busy.data_ok"}, 64'(dresp.data_ok), 64'(0));
    dreq = '0;
    for (int i = 0; i < v.wait_n; i++) begin
      step();
      cyc++;
      chk({tag, ".wait.creq.valid"}, 64'(creq.valid), 64'(1));
      chk({tag, ".wait.data_ok"}, 64'(dresp.data_ok), 64'(0));
    end
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = v.rdata;
    step();
    cyc++;
    cresp = '0;
    chk({tag, ".done.data_ok"}, 64'(dresp.data_ok), 64'(1));
    chk({tag, ".done.addr_ok"}, 64'(dresp.addr_ok), 64'(1));
    chk({tag, ".done.data"}, dresp.data, v.exp_resp);
    chk({tag, ".done.creq.valid"}, 64'(creq.valid), 64'(0));
    chk({tag, ".latency"}, 64'(cyc), 64'(v.exp_lat));
    step();
    chk({tag, ".idle.data_ok"}, 64'(dresp.data_ok), 64'(0));
    chk({tag, ".idle.addr_ok"}, 64'(dresp.addr_ok), 64'(0));
    chk({tag, ".idle.creq.valid"}, 64'(creq.valid), 64'(0));
  endtask

  initial begin
    int t0;

    vecs[0] = '{64'h0000_0000_1000_0008, MSIZE8, 8'h00, 64'h1111_2222_3333_4444, 3,
                64'hDEAD_BEEF_0123_4567, 1'b0, 64'hDEAD_BEEF_0123_4567, 5};
    vecs[1] = '{64'h0000_0000_1000_0001, MSIZE1, 8'b0000_0010, 64'h0000_0000_0000_AB00, 0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 2};
    vecs[2] = '{64'h0000_0000_2000_0003, MSIZE4, 8'h00, 64'h0, 1,
                64'h1122_3344_5566_7788, 1'b0, 64'h1122_3344_5566_7788, 3};
    vecs[3] = '{64'h8000_0000_0000_0010, MSIZE8, 8'hFF, 64'hCAFE_F00D_1234_5678, 2,
                64'h5555_5555_5555_5555, 1'b1, 64'h0, 4};

    reset = 1'b0;
    dreq  = '0;
    cresp = '0;
    dreq.valid = 1'b1;
    repeat (2) step();
    chk("rst.creq_nonzero", 64'(creq != '0), 64'(0));
    chk("rst.dresp_nonzero", 64'(dresp != '0), 64'(0));
    dreq  = '0;
    reset = 1'b1;
    step();
    chk("post_rst.creq.valid", 64'(creq.valid), 64'(0));

    for (int i = 0; i < 4; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back reads, each presented in the cycle after the previous data_ok.
    t0 = n_txn;
    run_txn("b2b0", vecs[0]);
    run_txn("b2b1", vecs[2]);
    chk("b2b.txn_count", 64'(n_txn - t0), 64'(2));

    // Protocol error (ready without last) plus dreq changing and dropping mid-BUSY.
    t0          = n_txn;
    dreq        = '0;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_4000_0020;
    dreq.size   = MSIZE8;
    step();
    dreq.addr   = 64'h0000_0000_DEAD_0000;
    dreq.strobe = 8'hFF;
    cresp.ready = 1'b1;
    cresp.last  = 1'b0;
    cresp.data  = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    chk("perr.creq.valid", 64'(creq.valid), 64'(1));
    chk("perr.creq.addr", creq.addr, 64'h0000_0000_4000_0020);
    chk("perr.creq.is_write", 64'(creq.is_write), 64'(0));
    chk("perr.data_ok", 64'(dresp.data_ok), 64'(0));
    dreq = '0;
    step();
    chk("perr2.creq.valid", 64'(creq.valid), 64'(1));
    chk("perr2.data_ok", 64'(dresp.data_ok), 64'(0));
    cresp.last = 1'b1;
    cresp.data = 64'h0F0F_0F0F_A5A5_A5A5;
    step();
    cresp = '0;
    chk("perr.done.data_ok", 64'(dresp.data_ok), 64'(1));
    chk("perr.done.data", dresp.data, 64'h0F0F_0F0F_A5A5_A5A5);
    step();
    chk("perr.idle.data_ok", 64'(dresp.data_ok), 64'(0));
    chk("perr.txn_count", 64'(n_txn - t0), 64'(1));

    // Reset while BUSY: bus response arriving afterwards must be ignored.
    dreq       = '0;
    dreq.valid = 1'b1;
    dreq.addr  = 64'h0000_0000_5000_0000;
    step();
    dreq = '0;
    chk("rbusy.creq.valid", 64'(creq.valid), 64'(1));
    reset = 1'b0;
    step();
    chk("rbusy.creq_nonzero", 64'(creq != '0), 64'(0));
    chk("rbusy.dresp_nonzero", 64'(dresp != '0), 64'(0));
    reset       = 1'b1;
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'h7777_7777_7777_7777;
    step();
    chk("late.data_ok", 64'(dresp.data_ok), 64'(0));
    chk("late.creq.valid", 64'(creq.valid), 64'(0));
    cresp = '0;
    step();
    chk("late2.data_ok", 64'(dresp.data_ok), 64'(0));
    run_txn("after_rst", vecs[2]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
